// File: rtl/seg7_scan_driver_pkg.sv
// ============================================================================
// seg7_scan_driver_pkg : shared 7-segment patterns and BCD width   rev 1.0
// ============================================================================
`default_nettype none

package seg7_scan_driver_pkg;

  localparam int BCD_W = 4;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

`default_nettype wire

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// ============================================================================
// bcd_to_seg7 : combinational BCD to active-high 7-segment decoder   rev 1.0
// ============================================================================
`default_nettype none

module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       pattern
);

  // Non-decimal codes A-F decode to blank
  always_comb begin
    pattern = SEG_BLANK;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : multiplexed BCD display driver with frame-aligned shadow
//                    capture; SEG7_LZB_EN enables leading-zero blanking  rev 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BCD_W*DIGITS-1:0] digits_in,
  output logic [6:0]              seg,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_tick
);

  localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             INV      = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SEG_OFF = {7{INV}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{INV}};

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        scan_idx;
  logic [BCD_W*DIGITS-1:0] shadow;
  logic                    tick;
  logic                    capture;
  logic [BCD_W-1:0]        digit_arr [DIGITS];
  logic [BCD_W-1:0]        cur_digit;
  logic [6:0]              decoded;
  logic [6:0]              seg_pattern;
  logic [DIGITS-1:0]       lzb_blank;
  logic [DIGITS-1:0]       an_onehot;

  assign tick       = (prescaler == PRE_LAST);
  assign capture    = tick && (scan_idx == IDX_LAST);
  assign frame_tick = capture && !reset;

  // Capture coincides with the scan wrap, so digit 0 of a frame always shows fresh data
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
      shadow    <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end
      if (capture) begin
        shadow <= digits_in;
      end
    end
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign digit_arr[k] = shadow[BCD_W*k +: BCD_W];
    end
  endgenerate

  assign cur_digit = digit_arr[scan_idx];

  bcd_to_seg7 u_dec (
    .bcd     (cur_digit),
    .pattern (decoded)
  );

`ifdef SEG7_LZB_EN
  // zero_from[k]: digit k and every higher digit of the shadow are zero
  logic [DIGITS:1] zero_from;
  assign zero_from[DIGITS] = 1'b1;
  assign lzb_blank[0]      = 1'b0;
  generate
    for (genvar k = 1; k < DIGITS; k++) begin : g_lzb
      assign zero_from[k] = (digit_arr[k] == '0) && zero_from[k+1];
      assign lzb_blank[k] = zero_from[k];
    end
  endgenerate
`else
  assign lzb_blank = '0;
`endif

  assign seg_pattern = lzb_blank[scan_idx] ? SEG_BLANK : decoded;
  assign an_onehot   = DIGITS'(1) << scan_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_pattern ^ SEG_OFF;
      an  <= an_onehot ^ AN_OFF;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : directed bench, active-high and active-low instances
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [6:0]  seg_h, seg_l;
  logic [3:0]  an_h, an_l;
  logic        ft_h, ft_l;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .seg        (seg_h),
    .an         (an_h),
    .frame_tick (ft_h)
  );

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_al (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .seg        (seg_l),
    .an         (an_l),
    .frame_tick (ft_l)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  // Checks both polarities against one active-high expectation
  task automatic chk_disp(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    check({tag, " an"},     {4'h0, an_h}, {4'h0, an_exp});
    check({tag, " seg"},    {1'b0, seg_h}, {1'b0, seg_exp});
    check({tag, " an_al"},  {4'h0, an_l}, {4'h0, ~an_exp});
    check({tag, " seg_al"}, {1'b0, seg_l}, {1'b0, ~seg_exp});
  endtask

  task automatic chk_ft(input string tag, input logic exp);
    check({tag, " ft"},    {7'h0, ft_h}, {7'h0, exp});
    check({tag, " ft_al"}, {7'h0, ft_l}, {7'h0, exp});
  endtask

`ifdef SEG7_LZB_EN
  localparam logic [6:0] LZ_D2 = 7'h00;
  localparam logic [6:0] LZ_D3 = 7'h00;
`else
  localparam logic [6:0] LZ_D2 = 7'h3F;
  localparam logic [6:0] LZ_D3 = 7'h3F;
`endif

  initial begin
    reset     = 1'b1;
    digits_in = 16'h1234;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      @(negedge clk);
      chk_disp("reset", 4'h0, 7'h00);
      chk_ft("reset", 1'b0);
    end
    reset = 1'b0;

    // c counts cycles since the last reset edge; sampling on the falling edge
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      case (c)
        1:  chk_disp("first_digit0", 4'h1, 7'h3F);
        14: chk_ft("pre_capture", 1'b0);
        15: chk_ft("capture1", 1'b1);
        16: chk_ft("post_capture", 1'b0);
        17: chk_disp("f1_d0", 4'h1, 7'h66);
        20: digits_in = 16'h5678;
        21: chk_disp("f1_d1", 4'h2, 7'h4F);
        25: chk_disp("f1_d2", 4'h4, 7'h5B);
        29: chk_disp("f1_d3", 4'h8, 7'h06);
        31: chk_ft("capture2", 1'b1);
        32: chk_disp("f1_d3_last", 4'h8, 7'h06);
        33: chk_disp("f2_d0", 4'h1, 7'h7F);
        37: chk_disp("f2_d1", 4'h2, 7'h07);
        40: digits_in = 16'h5B78;
        41: chk_disp("f2_d2", 4'h4, 7'h7D);
        45: chk_disp("f2_d3", 4'h8, 7'h6D);
        47: chk_ft("capture3", 1'b1);
        49: chk_disp("f3_d0", 4'h1, 7'h7F);
        53: chk_disp("f3_d1", 4'h2, 7'h07);
        56: digits_in = 16'h0070;
        57: chk_disp("hex_blank_d2", 4'h4, 7'h00);
        61: chk_disp("f3_d3", 4'h8, 7'h6D);
        65: chk_disp("lz_d0", 4'h1, 7'h3F);
        69: chk_disp("lz_d1", 4'h2, 7'h07);
        73: chk_disp("lz_d2", 4'h4, LZ_D2);
        77: chk_disp("lz_d3", 4'h8, LZ_D3);
        89: begin
          chk_disp("pre_reset_d2", 4'h4, LZ_D2);
          reset = 1'b1;
        end
        90: begin
          chk_disp("mid_reset", 4'h0, 7'h00);
          chk_ft("mid_reset", 1'b0);
          reset = 1'b0;
        end
        91: chk_disp("rst_d0_first", 4'h1, 7'h3F);
        94: chk_disp("rst_d0_last", 4'h1, 7'h3F);
        95: chk_disp("rst_d1_shadow_cleared", 4'h2, 7'h3F);
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
